if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch stage between the PC generator and the decode stage.
//  - Turns each PC + fetch-enable pair into a read of the synchronous instruction memory.
//  - Captures the returned word together with its PC in a small FIFO.
//  - Presents the oldest {pc, inst} pair to decode through a valid/ready handshake.
//  - Back-pressures the PC generator with pc_stall. Flushes on redirect.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  AW     32  instruction address width
//  DW     32  instruction word width
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  pc_in       in   AW            fetch address from the PC generator
//  inst_ce     in   1             fetch enable from the PC generator
//  pc_stall    out  1             PC generator must hold pc_in this cycle
//  imem_en     out  1             instruction-memory read enable
//  imem_addr   out  AW            instruction-memory read address
//  imem_rdata  in   DW            read data; valid the cycle after imem_en
//  flush       in   1             discard all buffered and in-flight fetches
//  id_valid    out  1             head entry valid to decode
//  id_ready    in   1             decode accepts head entry
//  id_pc       out  AW            PC of head entry
//  id_inst     out  DW            instruction of head entry
//  count       out  $clog2(DEPTH)+1  number of occupied FIFO entries
// BEHAVIOUR
//  - Reset (async): count=0, id_valid=0, in-flight flag=0, pc_stall=0, imem_en=0.
//    FIFO pointers cleared. Entry contents are don't-care.
//  - Issue rule: imem_en = inst_ce & ~pc_stall & ~flush & ~rst. imem_addr = pc_in
//    (combinational pass-through). pc_in is sampled into pend_pc on an issue.
//  - In-flight flag: set the cycle after an issue, clear otherwise. At most 1 request in flight.
//  - Capture: when the in-flight flag is set and flush=0, write {pend_pc, imem_rdata}
//    at the tail at the clock edge.
//  - Credit: pc_stall = (count + inflight) >= DEPTH. Derived only from registers, never from id_ready.
//    - An unissued pc_in is re-presented by the PC generator, which holds while stalled.
//    - Overflow is impossible by construction.
//  - Latency: issue in cycle N -> imem_rdata in N+1 -> id_valid earliest in N+2 (FIFO empty case).
//  - Pop: on id_valid & id_ready, head advances.
//    - Simultaneous pop and capture: count unchanged.
//    - Pop when empty: ignored.
//  - id_valid = (count != 0). id_pc and id_inst are read combinationally from the head entry.
//    Both stay stable while id_valid & ~id_ready.
//  - Order: entries reach decode strictly in issue order. Pointers wrap modulo DEPTH.
//  - Flush (synchronous, 1 cycle):
//    - Next cycle: count=0, id_valid=0, pointers reset, in-flight flag cleared.
//    - A response arriving in the flush cycle is dropped. No issue in the flush cycle.
//    - A pop in the flush cycle is ignored.
//    - Flush has priority over capture and pop.
//  - rst asserted mid-operation: all state clears immediately. No partial entries survive.
// CONFIGURATION
//  - FETCH_STATS_EN defined: adds outputs stat_fetched[31:0] and stat_stalls[31:0].
//    - stat_fetched: +1 per FIFO capture.
//    - stat_stalls: +1 per cycle with inst_ce & pc_stall.
//    - Reset to 0 by rst only; not cleared by flush. Wraps at 2^32.
//  - FETCH_STATS_EN undefined: both ports and their counters are absent. Core behaviour is identical.
// TESTING
//  1. rst, then inst_ce=1, id_ready=1, pc_in=0,4,8..., imem returns mem[pc]
//     -> id_pc=0 valid at cycle 2, one new entry per cycle, count<=1, pc_stall never 1.
//  2. DEPTH=4, id_ready=0, continuous fetch
//     -> 4 issues, then pc_stall=1, count=4, imem_en=0.
//     Then id_ready=1 -> pops pc 0x0,0x4,0x8,0xC in order, pc_stall drops after the first pop.
//  3. 2 entries buffered + 1 in flight, flush=1 for 1 cycle
//     -> next cycle count=0, id_valid=0, the in-flight word is never presented.
//  4. count=2, id_ready=1 and a capture in the same cycle
//     -> count stays 2, head advances, new entry lands at tail.
//  5. rst pulse (async, between edges) while count=3
//     -> count=0, id_valid=0, pc_stall=0, imem_en=0 without waiting for a clk edge.
//  6. FETCH_STATS_EN: scenario 2 with 6 stalled cycles and 8 captures
//     -> stat_stalls=6, stat_fetched=8. A flush leaves both unchanged.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-queue bundle: PC request, imem read port, decode handshake
interface if_fetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0] pc_in;
    logic          inst_ce;
    logic          pc_stall;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    // The fetch queue itself
    modport master (
        input  pc_in, inst_ce, imem_rdata, flush, id_ready,
        output pc_stall, imem_en, imem_addr, id_valid, id_pc, id_inst
    );

    // PC generator, instruction memory and decode as seen from outside
    modport slave (
        output pc_in, inst_ce, imem_rdata, flush, id_ready,
        input  pc_stall, imem_en, imem_addr, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch queue, optional FETCH_STATS_EN counters
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    if_fetch_queue_if.master         bus,
`ifdef FETCH_STATS_EN
    output logic [31:0]              stat_fetched,
    output logic [31:0]              stat_stalls,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          inflight;
    logic [AW-1:0] pend_pc;
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic          issue;
    logic          capture;
    logic          pop;
    logic [CW:0]   credit_used;

    // Credit check from registered state only, plus issue/capture/pop qualifiers
    always_comb begin
        credit_used   = {1'b0, count} + {{CW{1'b0}}, inflight};
        bus.pc_stall  = (credit_used >= (CW + 1)'(DEPTH));
        issue         = bus.inst_ce & ~bus.pc_stall & ~bus.flush & ~rst;
        capture       = inflight & ~bus.flush;
        bus.id_valid  = (count != '0);
        pop           = bus.id_valid & bus.id_ready & ~bus.flush;
        bus.imem_en   = issue;
        bus.imem_addr = bus.pc_in;
        bus.id_pc     = pc_mem[head];
        bus.id_inst   = inst_mem[head];
    end

    // Pointers, occupancy and the single outstanding-request tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            pend_pc  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pend_pc <= bus.pc_in;
            end
            if (bus.flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (capture) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                case ({capture, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_mem[tail]   <= pend_pc;
            inst_mem[tail] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_STATS_EN
    // Capture and stall counters; only rst clears them, flush leaves them alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_stalls  <= '0;
        end else begin
            if (capture) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (bus.inst_ce & bus.pc_stall) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
